alb: RTL and testbench
======================

# alb

8-bit arithmetic/logic block: combines operands R and S under a 2-bit mode select into an 8-bit result F with carry, zero, negative and overflow flags. It is the datapath ALU slice of the processor core. A stimulus generator and a self-checking comparator sit around it in simulation. Result and flags are registered, with one-cycle latency.

## Interface
Parameters: none. Width is fixed at 8 bits.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `resetb`  input  1  reset; synchronous, active-low.
- `R`  input  8  operand R.
- `S`  input  8  operand S.
- `CI`  input  1  carry-in; used by arithmetic modes only.
- `ALB_MI`  input  2  mode select.
- `F`  output  8  registered result.
- `CO`  output  1  registered carry-out.
- `ZO`  output  1  registered zero flag.
- `NO`  output  1  registered negative flag.
- `VO`  output  1  registered signed-overflow flag.

## Operation
- `ALB_MI`=00 (OR): F = R | S.
- `ALB_MI`=01 (ADD): {CO,F} = R + S + CI, 9-bit sum.
- `ALB_MI`=10 (RSUB): {CO,F} = S + ~R + CI, 9-bit sum.
  - CI=1 gives S−R.
  - CO=1 means no borrow.
- `ALB_MI`=11 (XOR): F = R ^ S.
- CO: bit 8 of the sum in modes 01/10; 0 in logic modes.
- ZO = (F == 8'h00) in all modes.
- NO = F[7] in all modes.
- VO (two's-complement overflow) in mode 01: (R[7]==S[7]) && (F[7]!=R[7]).
- VO in mode 10: the addends are A=~R and S; VO = (A[7]==S[7]) && (F[7]!=S[7]).
- VO is 0 in logic modes.
- All four mode codes are defined; no default/X path.
- CI is ignored in logic modes.

## Timing
- Operands, CI and mode are sampled at each rising `clk` edge.
- F/CO/ZO/NO/VO reflect those inputs after that edge and hold until the next edge.
- Latency: exactly 1 cycle.
- Throughput: one operation per cycle; no handshake, no stall.
- Reset, `resetb`=0 at a rising edge:
  - F=8'h00, CO=0, ZO=0, NO=0, VO=0. ZO is 0 in reset, not derived from F.
  - Reset has priority over any input activity, including mid-operation; the in-flight result is discarded.
- First edge with `resetb`=1 captures the current inputs normally.
- Flags always update together with F, from the same sampled inputs; no sticky state.
- Inputs changing between edges have no effect on the outputs.

## Structure
- Shared package `alb_pkg`:
  - mode constants `ALB_OR`=2'b00, `ALB_ADD`=2'b01, `ALB_RSUB`=2'b10, `ALB_XOR`=2'b11;
  - `ALB_W`=8.
- Sub-module `alb_adder8`:
  - combinational 8-bit adder (a, b, cin → sum, cout, ovf);
  - instantiated once, with b selected as S and a as R or ~R per mode.
- Top `alb`: combinational mode mux, flag logic, one output register stage.

## Test plan
- Reset: hold `resetb`=0 with R=8'hFF, S=8'hFF, mode 01 → after edge, F=00 and all flags 0. Release → next edge gives F=FE, CO=1, NO=1.
- OR/XOR:
  - R=0F, S=F0, mode 00 → F=FF, NO=1, ZO=0, CO=0, VO=0.
  - R=S=AA, mode 11, CI=1 → F=00, ZO=1, CO=0.
- ADD carry/overflow:
  - R=FF, S=01, CI=0 → F=00, CO=1, ZO=1, VO=0.
  - R=7F, S=01, CI=0 → F=80, VO=1, NO=1, CO=0.
- RSUB:
  - R=05, S=03, CI=1 → F=FE, CO=0, NO=1, VO=0.
  - R=S=42, CI=1 → F=00, CO=1, ZO=1.
  - R=01, S=80, CI=1 → F=7F, VO=1, CO=1.
- Latency/mid-op reset: change inputs every cycle → each output equals the previous cycle's inputs. Assert `resetb` for one cycle mid-stream → that cycle's output is zeros, then the stream resumes.
- Random regression: ≥10k random R/S/CI/mode per cycle → F and flags match the formulas above, delayed 1 cycle.

Source files
------------

// File: rtl/alb_pkg.sv
// Shared constants for the alb ALU slice: operand width and mode encodings.
package alb_pkg;

   localparam int ALB_W = 8;

   localparam logic [1:0] ALB_OR   = 2'b00;
   localparam logic [1:0] ALB_ADD  = 2'b01;
   localparam logic [1:0] ALB_RSUB = 2'b10;
   localparam logic [1:0] ALB_XOR  = 2'b11;

endpackage

// File: rtl/alb_if.sv
// Operand/result bundle for the alb ALU slice.
interface alb_if;
   import alb_pkg::*;

   logic [ALB_W-1:0] R;
   logic [ALB_W-1:0] S;
   logic             CI;
   logic [1:0]       ALB_MI;
   logic [ALB_W-1:0] F;
   logic             CO;
   logic             ZO;
   logic             NO;
   logic             VO;

   modport master (output R, S, CI, ALB_MI, input F, CO, ZO, NO, VO);
   modport slave  (input R, S, CI, ALB_MI, output F, CO, ZO, NO, VO);
endinterface

// File: rtl/alb_adder8.sv
// Combinational 8-bit adder with carry-out and two's-complement overflow.
module alb_adder8
   import alb_pkg::*;
(
   input  logic [ALB_W-1:0] a,
   input  logic [ALB_W-1:0] b,
   input  logic             cin,
   output logic [ALB_W-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{ALB_W{1'b0}}, cin};
   // Like-signed addends producing an opposite-signed sum is an overflow.
   assign ovf = (a[ALB_W-1] == b[ALB_W-1]) && (sum[ALB_W-1] != a[ALB_W-1]);

endmodule

// File: rtl/alb.sv
// ALU slice: OR / ADD / reverse-subtract / XOR with registered result and flags.
module alb
   import alb_pkg::*;
(
   input  logic  clk,
   input  logic  resetb,
   alb_if.slave  bus
);

   logic [ALB_W-1:0] add_a;
   logic [ALB_W-1:0] sum;
   logic             cout;
   logic             ovf;
   logic [ALB_W-1:0] f_nxt;
   logic             co_nxt;
   logic             vo_nxt;

   // RSUB computes S + ~R + CI, so only the R leg needs inverting.
   assign add_a = (bus.ALB_MI == ALB_RSUB) ? ~bus.R : bus.R;

   alb_adder8 u_adder (
      .a    (add_a),
      .b    (bus.S),
      .cin  (bus.CI),
      .sum  (sum),
      .cout (cout),
      .ovf  (ovf)
   );

   always_comb begin
      f_nxt  = sum;
      co_nxt = 1'b0;
      vo_nxt = 1'b0;
      unique case (bus.ALB_MI)
         ALB_OR:  f_nxt = bus.R | bus.S;
         ALB_ADD,
         ALB_RSUB: begin
            co_nxt = cout;
            vo_nxt = ovf;
         end
         ALB_XOR: f_nxt = bus.R ^ bus.S;
      endcase
   end

   // Zero flag is forced low during reset rather than derived from F.
   always_ff @(posedge clk) begin
      if (!resetb) begin
         bus.F  <= '0;
         bus.CO <= 1'b0;
         bus.ZO <= 1'b0;
         bus.NO <= 1'b0;
         bus.VO <= 1'b0;
      end else begin
         bus.F  <= f_nxt;
         bus.CO <= co_nxt;
         bus.ZO <= (f_nxt == '0);
         bus.NO <= f_nxt[ALB_W-1];
         bus.VO <= vo_nxt;
      end
   end

endmodule

// File: tb/tb_alb.sv
// Directed and random checks of the alb ALU slice against hand values and a reference model.
module tb_alb;
   import alb_pkg::*;

   logic clk = 1'b0;
   logic resetb;
   int   checks = 0;
   int   failures = 0;

   alb_if bus ();

   alb dut (
      .clk    (clk),
      .resetb (resetb),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] pack(input logic [7:0] f, input logic co, input logic zo,
                                        input logic no, input logic vo);
      return {f, co, zo, no, vo};
   endfunction

   function automatic logic [11:0] model(input logic [7:0] r, input logic [7:0] s,
                                         input logic ci, input logic [1:0] m);
      logic [8:0] t;
      logic [7:0] a;
      logic [7:0] f;
      logic       co;
      logic       vo;
      int         sv;
      co = 1'b0;
      vo = 1'b0;
      f  = 8'h00;
      case (m)
         ALB_OR:  f = r | s;
         ALB_XOR: f = r ^ s;
         default: begin
            a  = (m == ALB_RSUB) ? ~r : r;
            t  = {1'b0, a} + {1'b0, s} + {8'h00, ci};
            f  = t[7:0];
            co = t[8];
            sv = int'($signed(a)) + int'($signed(s)) + (ci ? 1 : 0);
            vo = (sv > 127) || (sv < -128);
         end
      endcase
      return {f, co, (f == 8'h00), f[7], vo};
   endfunction

   task automatic drive(input logic [7:0] r, input logic [7:0] s, input logic ci,
                        input logic [1:0] m);
      @(negedge clk);
      bus.R      = r;
      bus.S      = s;
      bus.CI     = ci;
      bus.ALB_MI = m;
   endtask

   task automatic expect_out(input string tag, input logic [11:0] exp);
      logic [11:0] obs;
      @(posedge clk);
      #1;
      obs = {bus.F, bus.CO, bus.ZO, bus.NO, bus.VO};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed F/C/Z/N/V=%h/%b%b%b%b expected=%h/%b%b%b%b", tag,
                obs[11:4], obs[3], obs[2], obs[1], obs[0],
                exp[11:4], exp[3], exp[2], exp[1], exp[0]);
      end
   endtask

   initial begin
      logic [7:0] r;
      logic [7:0] s;
      logic       ci;
      logic [1:0] m;

      resetb     = 1'b0;
      bus.R      = 8'hFF;
      bus.S      = 8'hFF;
      bus.CI     = 1'b0;
      bus.ALB_MI = ALB_ADD;

      // Reset holds zeros even with live operands.
      drive(8'hFF, 8'hFF, 1'b0, ALB_ADD);
      expect_out("reset", pack(8'h00, 0, 0, 0, 0));
      @(negedge clk);
      resetb = 1'b1;
      expect_out("first_after_reset", pack(8'hFE, 1, 0, 1, 0));

      drive(8'h0F, 8'hF0, 1'b0, ALB_OR);
      expect_out("or", pack(8'hFF, 0, 0, 1, 0));
      drive(8'h00, 8'h00, 1'b1, ALB_OR);
      expect_out("or_zero_ci_ignored", pack(8'h00, 0, 1, 0, 0));
      drive(8'hAA, 8'hAA, 1'b1, ALB_XOR);
      expect_out("xor_zero", pack(8'h00, 0, 1, 0, 0));
      drive(8'h3C, 8'h0F, 1'b0, ALB_XOR);
      expect_out("xor", pack(8'h33, 0, 0, 0, 0));

      drive(8'hFF, 8'h01, 1'b0, ALB_ADD);
      expect_out("add_carry", pack(8'h00, 1, 1, 0, 0));
      drive(8'h7F, 8'h01, 1'b0, ALB_ADD);
      expect_out("add_ovf", pack(8'h80, 0, 0, 1, 1));
      drive(8'h10, 8'h20, 1'b1, ALB_ADD);
      expect_out("add_ci", pack(8'h31, 0, 0, 0, 0));

      drive(8'h05, 8'h03, 1'b1, ALB_RSUB);
      expect_out("rsub_borrow", pack(8'hFE, 0, 0, 1, 0));
      drive(8'h42, 8'h42, 1'b1, ALB_RSUB);
      expect_out("rsub_zero", pack(8'h00, 1, 1, 0, 0));
      drive(8'h01, 8'h80, 1'b1, ALB_RSUB);
      expect_out("rsub_ovf", pack(8'h7F, 1, 0, 0, 1));

      // Back-to-back stream with a one-cycle reset in the middle.
      drive(8'h10, 8'h20, 1'b1, ALB_ADD);
      expect_out("stream0", pack(8'h31, 0, 0, 0, 0));
      drive(8'h55, 8'h0F, 1'b0, ALB_XOR);
      resetb = 1'b0;
      expect_out("stream_reset", pack(8'h00, 0, 0, 0, 0));
      @(negedge clk);
      resetb = 1'b1;
      expect_out("stream_resume", pack(8'h5A, 0, 0, 0, 0));
      drive(8'h80, 8'h80, 1'b0, ALB_ADD);
      expect_out("stream_add_neg_ovf", pack(8'h00, 1, 1, 0, 1));

      // Inputs toggled after the edge must not disturb the held outputs.
      drive(8'h01, 8'h02, 1'b0, ALB_OR);
      expect_out("hold_pre", pack(8'h03, 0, 0, 0, 0));
      bus.R = 8'hFF;
      bus.ALB_MI = ALB_XOR;
      #2;
      checks++;
      assert ({bus.F, bus.CO, bus.ZO, bus.NO, bus.VO} === pack(8'h03, 0, 0, 0, 0)) else begin
         failures++;
         $error("FAIL hold observed F=%h expected=03", bus.F);
      end

      for (int i = 0; i < 10000; i++) begin
         r  = 8'($urandom);
         s  = 8'($urandom);
         ci = 1'($urandom);
         m  = 2'($urandom);
         drive(r, s, ci, m);
         expect_out($sformatf("rand%0d", i), model(r, s, ci, m));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
